// File: rtl/countdown_timer.sv
// Loadable down-counter timer. It emits a one-cycle tick after a programmable
// number of enable strobes, either once (one-shot) or repeatedly (auto-reload).
module countdown_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_L,
   input  logic         start,
   input  logic         stop,
   input  logic         pause,
   input  logic         en,
   input  logic         periodic,
   input  logic [W-1:0] period,
   output logic [W-1:0] q,
   output logic         tick,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   state_t       state;
   logic [W-1:0] load_value;

   // A zero period would never expire, so it is promoted to one.
   assign load_value = (period == '0) ? ONE : period;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state <= IDLE;
         q     <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (stop) begin
            state <= IDLE;
            q     <= '0;
         end else if (start) begin
            state <= RUN;
            q     <= load_value;
         end else begin
            case (state)
               RUN: begin
                  if (pause) begin
                     state <= HOLD;
                  end else if (en) begin
                     // Expiry is tested before decrementing so q never wraps.
                     if (q == ONE) begin
                        tick <= 1'b1;
                        if (periodic) begin
                           q <= load_value;
                        end else begin
                           q     <= '0;
                           state <= DONE;
                        end
                     end else if (q != '0) begin
                        q <= q - ONE;
                     end
                  end
               end
               HOLD: begin
                  if (!pause) begin
                     state <= RUN;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign busy = (state == RUN) || (state == HOLD);
   assign done = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer at W=8; each task covers
// one scenario and compares {q, tick, busy, done} against hand-derived values.
module tb_countdown_timer;

   logic       clk;
   logic       reset_L;
   logic       start;
   logic       stop;
   logic       pause;
   logic       en;
   logic       periodic;
   logic [7:0] period;
   logic [7:0] q;
   logic       tick;
   logic       busy;
   logic       done;

   int checks_total;
   int checks_passed;

   countdown_timer #(.W(8)) dut (
      .clk      (clk),
      .reset_L  (reset_L),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .en       (en),
      .periodic (periodic),
      .period   (period),
      .q        (q),
      .tick     (tick),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      start = 1'b0;
      pause = 1'b0;
      stop  = 1'b1;
      step();
      stop  = 1'b0;
   endtask

   task automatic test_reset();
      reset_L = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      en = 1'b0; periodic = 1'b0; period = 8'd0;
      #12;
      checks_total++;
      if ({q, tick, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0})
         $display("[TB] FAIL reset_state got q=%0d tick=%b busy=%b done=%b want q=0 tick=0 busy=0 done=0",
                  q, tick, busy, done);
      else checks_passed++;
      reset_L = 1'b1;
      en = 1'b1;
      step();
      checks_total++;
      if ({q, busy, done} !== {8'd0, 1'b0, 1'b0})
         $display("[TB] FAIL reset_release got q=%0d busy=%b done=%b want q=0 busy=0 done=0", q, busy, done);
      else checks_passed++;
   endtask

   task automatic test_one_shot();
      logic [7:0] exp_q [6] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      go_idle();
      period = 8'd5; periodic = 1'b0; en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      checks_total++;
      if ({q, tick, busy, done} !== {8'd5, 1'b0, 1'b1, 1'b0})
         $display("[TB] FAIL oneshot_load got q=%0d tick=%b busy=%b done=%b want q=5 tick=0 busy=1 done=0",
                  q, tick, busy, done);
      else checks_passed++;
      for (int i = 1; i < 6; i++) begin
         step();
         checks_total++;
         if ({q, tick, busy, done} !== {exp_q[i], i == 5, i != 5, i == 5})
            $display("[TB] FAIL oneshot_count[%0d] got q=%0d tick=%b busy=%b done=%b want q=%0d tick=%b busy=%b done=%b",
                     i, q, tick, busy, done, exp_q[i], i == 5, i != 5, i == 5);
         else checks_passed++;
      end
      for (int i = 0; i < 20; i++) begin
         step();
         checks_total++;
         if ({q, tick, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b1})
            $display("[TB] FAIL oneshot_hold[%0d] got q=%0d tick=%b busy=%b done=%b want q=0 tick=0 busy=0 done=1",
                     i, q, tick, busy, done);
         else checks_passed++;
      end
   endtask

   task automatic test_periodic();
      logic [7:0] exp_full [9]  = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
      logic [7:0] exp_gated [12] = '{2, 2, 1, 1, 3, 3, 2, 2, 1, 1, 3, 3};
      logic [7:0] exp_new [3]   = '{2, 1, 2};
      go_idle();
      period = 8'd3; periodic = 1'b1; en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      checks_total++;
      if ({q, tick} !== {8'd3, 1'b0})
         $display("[TB] FAIL periodic_load got q=%0d tick=%b want q=3 tick=0", q, tick);
      else checks_passed++;
      for (int i = 0; i < 9; i++) begin
         step();
         checks_total++;
         if ({q, tick, busy} !== {exp_full[i], (i % 3) == 2, 1'b1})
            $display("[TB] FAIL periodic_full[%0d] got q=%0d tick=%b busy=%b want q=%0d tick=%b busy=1",
                     i, q, tick, busy, exp_full[i], (i % 3) == 2);
         else checks_passed++;
      end

      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         en = k[0];
         step();
         checks_total++;
         if ({q, tick} !== {exp_gated[k-1], (k == 5) || (k == 11)})
            $display("[TB] FAIL periodic_gated[%0d] got q=%0d tick=%b want q=%0d tick=%b",
                     k, q, tick, exp_gated[k-1], (k == 5) || (k == 11));
         else checks_passed++;
      end

      period = 8'd2; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks_total++;
         if ({q, tick} !== {exp_new[i], i == 2})
            $display("[TB] FAIL periodic_newperiod[%0d] got q=%0d tick=%b want q=%0d tick=%b",
                     i, q, tick, exp_new[i], i == 2);
         else checks_passed++;
      end
   endtask

   task automatic test_pause();
      logic [7:0] exp_run [5] = '{4, 3, 2, 1, 0};
      go_idle();
      period = 8'd6; periodic = 1'b0; en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      checks_total++;
      if (q !== 8'd4)
         $display("[TB] FAIL pause_prelude got q=%0d want q=4", q);
      else checks_passed++;
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks_total++;
         if ({q, tick, busy} !== {8'd4, 1'b0, 1'b1})
            $display("[TB] FAIL pause_hold[%0d] got q=%0d tick=%b busy=%b want q=4 tick=0 busy=1",
                     i, q, tick, busy);
         else checks_passed++;
      end
      pause = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks_total++;
         if ({q, tick, done} !== {exp_run[i], i == 4, i == 4})
            $display("[TB] FAIL pause_resume[%0d] got q=%0d tick=%b done=%b want q=%0d tick=%b done=%b",
                     i, q, tick, done, exp_run[i], i == 4, i == 4);
         else checks_passed++;
      end

      period = 8'd2; periodic = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      pause = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks_total++;
         if ({q, tick, busy} !== {8'd1, 1'b0, 1'b1})
            $display("[TB] FAIL pause_at_expiry[%0d] got q=%0d tick=%b busy=%b want q=1 tick=0 busy=1",
                     i, q, tick, busy);
         else checks_passed++;
      end
      pause = 1'b0;
   endtask

   task automatic test_priority();
      go_idle();
      period = 8'd3; periodic = 1'b0; en = 1'b1; start = 1'b1;
      step();
      stop = 1'b1;
      step();
      stop = 1'b0; start = 1'b0;
      checks_total++;
      if ({q, tick, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0})
         $display("[TB] FAIL prio_stop_start got q=%0d tick=%b busy=%b done=%b want q=0 tick=0 busy=0 done=0",
                  q, tick, busy, done);
      else checks_passed++;

      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      checks_total++;
      if ({q, tick, busy} !== {8'd3, 1'b0, 1'b1})
         $display("[TB] FAIL prio_start_on_expiry got q=%0d tick=%b busy=%b want q=3 tick=0 busy=1",
                  q, tick, busy);
      else checks_passed++;

      step();
      step();
      step();
      checks_total++;
      if ({q, tick, done} !== {8'd0, 1'b1, 1'b1})
         $display("[TB] FAIL prio_reach_done got q=%0d tick=%b done=%b want q=0 tick=1 done=1", q, tick, done);
      else checks_passed++;
      period = 8'd4; start = 1'b1;
      step();
      start = 1'b0;
      checks_total++;
      if ({q, busy, done} !== {8'd4, 1'b1, 1'b0})
         $display("[TB] FAIL prio_start_from_done got q=%0d busy=%b done=%b want q=4 busy=1 done=0",
                  q, busy, done);
      else checks_passed++;
   endtask

   task automatic test_period_zero();
      go_idle();
      period = 8'd0; periodic = 1'b1; en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      checks_total++;
      if ({q, tick, busy} !== {8'd1, 1'b0, 1'b1})
         $display("[TB] FAIL zero_load got q=%0d tick=%b busy=%b want q=1 tick=0 busy=1", q, tick, busy);
      else checks_passed++;
      for (int i = 0; i < 5; i++) begin
         step();
         checks_total++;
         if ({q, tick} !== {8'd1, 1'b1})
            $display("[TB] FAIL zero_tick[%0d] got q=%0d tick=%b want q=1 tick=1", i, q, tick);
         else checks_passed++;
      end
   endtask

   task automatic test_async_reset();
      go_idle();
      period = 8'd5; periodic = 1'b0; en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      #3;
      reset_L = 1'b0;
      #1;
      checks_total++;
      if ({q, tick, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0})
         $display("[TB] FAIL async_reset got q=%0d tick=%b busy=%b done=%b want q=0 tick=0 busy=0 done=0",
                  q, tick, busy, done);
      else checks_passed++;
      #2;
      reset_L = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks_total++;
         if ({q, tick, busy} !== {8'd0, 1'b0, 1'b0})
            $display("[TB] FAIL async_after_release[%0d] got q=%0d tick=%b busy=%b want q=0 tick=0 busy=0",
                     i, q, tick, busy);
         else checks_passed++;
      end
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      test_reset();
      test_one_shot();
      test_periodic();
      test_pause();
      test_priority();
      test_period_zero();
      test_async_reset();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
